// File: rtl/rx_sched_pkg.sv
// Shared TLP field positions, routing constants and FSM encoding for the RX packet scheduler.
package rx_sched_pkg;

    localparam int BAR_W    = 8;
    // Sideband bit positions, counted down from the MSB of the FIFO word.
    localparam int SOP_OFS  = 1;
    localparam int EOP_OFS  = 2;
    localparam int BAR_OFS  = 10;

    localparam int FMT_LSB  = 29;
    localparam int FMT_W    = 3;
    localparam int TYPE_LSB = 24;
    localparam int TYPE_W   = 5;

    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;
    typedef enum logic [1:0] {DEST_CW, DEST_CR, DEST_RC, DEST_NONE} dest_t;

    function automatic dest_t classify(input logic [FMT_W-1:0] fmt, input logic [TYPE_W-1:0] typ);
        if (typ == TYPE_CPL) return DEST_RC;
        if (typ == TYPE_MEM && fmt[2:1] == 2'b00) return DEST_CR;
        if (typ == TYPE_MEM && fmt[2:1] == 2'b01) return DEST_CW;
        return DEST_NONE;
    endfunction

endpackage

// File: rtl/rx_np_credit.sv
// Non-posted credit counter: one credit per outstanding host read, saturating at NP_CREDITS.
module rx_np_credit #(
    parameter int NP_CREDITS = 4
) (
    input  logic axi_clk,
    input  logic axi_rst,
    input  logic credit_take,
    input  logic credit_ret,
    output logic credit_avail,
    output logic credit_err
);

    localparam int CW = $clog2(NP_CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(NP_CREDITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (credit_take && !credit_ret) begin
            cnt_d = cnt_q - ONE;
        end else if (credit_ret && !credit_take) begin
            if (cnt_q == FULL) err_d = 1'b1;
            else               cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            cnt_q <= FULL;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign credit_avail = (cnt_q != '0);
    assign credit_err   = err_q;

endmodule

// File: rtl/rx_pkt_scheduler.sv
// RX packet scheduler: steers TLPs from a show-ahead FIFO to the cw / cr / rc streams,
// dropping unroutable or headless packets.
//
// state | meaning
// IDLE  | wait for a complete packet at the head and an empty output register
// PASS  | forward beats of the current packet to dest_q
// DROP  | discard beats up to and including the next eop
module rx_pkt_scheduler
    import rx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 22,
    parameter int NP_CREDITS = 4,
    parameter int FIFO_W     = DATA_WIDTH + BE_WIDTH + 10
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    input  logic [FIFO_W-1:0]     fifo_q,
    input  logic                  fifo_empty,
    output logic                  fifo_rdreq,
    input  logic                  pkt_rdy,
    output logic                  pkt_pop,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [BE_WIDTH-1:0]   m_tstrb,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic                  cw_tvalid,
    output logic                  cr_tvalid,
    output logic                  rc_tvalid,
    input  logic                  cw_tready,
    input  logic                  cr_tready,
    input  logic                  rc_tready,
    input  logic                  cr_credit_ret,
    output logic [15:0]           drop_cnt,
    output logic                  credit_err
);

    logic                  head_sop, head_eop;
    logic [BAR_W-1:0]      head_bar;
    logic [BE_WIDTH-1:0]   head_be;
    logic [DATA_WIDTH-1:0] head_data;
    dest_t                 head_dest;

    assign head_sop  = fifo_q[FIFO_W-SOP_OFS];
    assign head_eop  = fifo_q[FIFO_W-EOP_OFS];
    assign head_bar  = fifo_q[FIFO_W-BAR_OFS +: BAR_W];
    assign head_be   = fifo_q[DATA_WIDTH +: BE_WIDTH];
    assign head_data = fifo_q[DATA_WIDTH-1:0];
    assign head_dest = classify(head_data[FMT_LSB +: FMT_W], head_data[TYPE_LSB +: TYPE_W]);

    state_t                state_q, state_d;
    dest_t                 dest_q, dest_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [BE_WIDTH-1:0]   out_strb_q, out_strb_d;
    logic                  out_last_q, out_last_d;
    logic [BAR_W-1:0]      out_bar_q, out_bar_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  sel_ready, credit_take, credit_avail;

    always_comb begin
        sel_ready = 1'b0;
        case (dest_q)
            DEST_CW: sel_ready = cw_tready;
            DEST_CR: sel_ready = cr_tready;
            DEST_RC: sel_ready = rc_tready;
            default: sel_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_bar_d   = out_bar_q;
        drop_cnt_d  = drop_cnt_q;
        fifo_rdreq  = 1'b0;
        credit_take = 1'b0;

        if (out_valid_q && sel_ready) out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Waiting on out_valid_q keeps the previous packet's last beat from being overtaken.
                if (pkt_rdy && !fifo_empty && !out_valid_q) begin
                    if (!head_sop || head_dest == DEST_NONE) begin
                        state_d = ST_DROP;
                    end else if (head_dest != DEST_CR || credit_avail) begin
                        state_d     = ST_PASS;
                        dest_d      = head_dest;
                        credit_take = (head_dest == DEST_CR);
                    end
                end
            end
            ST_PASS: begin
                fifo_rdreq = !fifo_empty && (!out_valid_q || sel_ready);
                if (fifo_rdreq) begin
                    out_valid_d = 1'b1;
                    out_data_d  = head_data;
                    out_strb_d  = head_be;
                    out_last_d  = head_eop;
                    out_bar_d   = head_bar;
                    if (head_eop) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                fifo_rdreq = !fifo_empty;
                if (fifo_rdreq && head_eop) begin
                    state_d = ST_IDLE;
                    if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_rst) begin
        if (!axi_rst) begin
            state_q     <= ST_IDLE;
            dest_q      <= DEST_CW;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_bar_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_bar_q   <= out_bar_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    rx_np_credit #(.NP_CREDITS(NP_CREDITS)) u_np_credit (
        .axi_clk      (axi_clk),
        .axi_rst      (axi_rst),
        .credit_take  (credit_take),
        .credit_ret   (cr_credit_ret),
        .credit_avail (credit_avail),
        .credit_err   (credit_err)
    );

    assign pkt_pop   = fifo_rdreq && head_eop;
    assign m_tdata   = out_data_q;
    assign m_tstrb   = out_strb_q;
    assign m_tlast   = out_last_q;
    assign m_tuser   = {{(USER_WIDTH-BAR_W){1'b0}}, out_bar_q};
    assign cw_tvalid = out_valid_q && (dest_q == DEST_CW);
    assign cr_tvalid = out_valid_q && (dest_q == DEST_CR);
    assign rc_tvalid = out_valid_q && (dest_q == DEST_RC);
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/rx_pkt_scheduler.md
RX_PKT_SCHEDULER -- requirements
Module: rx_pkt_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning the TLP data bus width.
REQ-002 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, meaning byte-enable/strobe width.
REQ-003 SHALL have parameter USER_WIDTH, default 22, meaning the tuser width.
REQ-004 SHALL have parameter NP_CREDITS, default 4, meaning the maximum number of outstanding host read requests on cr.
REQ-005 SHALL have parameter FIFO_W, default DATA_WIDTH+BE_WIDTH+10, meaning the FIFO word width.
REQ-006 SHALL have the following ports.
- axi_clk  in  1  sole clock.
- axi_rst  in  1  asynchronous, active-low reset.
- fifo_q  in  FIFO_W  show-ahead RX FIFO head word. Layout: [W-1] sop, [W-2] eop, [W-3:W-10] bar hit, then be, then data in the LSBs.
- fifo_empty  in  1  RX FIFO empty.
- fifo_rdreq  out  1  pop of the RX FIFO head.
- pkt_rdy  in  1  at least one complete packet is buffered (eop FIFO not empty).
- pkt_pop  out  1  one-cycle pulse per eop beat popped.
- m_tdata  out  DATA_WIDTH  shared output data.
- m_tstrb  out  BE_WIDTH  shared output strobe.
- m_tlast  out  1  shared output last.
- m_tuser  out  USER_WIDTH  [7:0] bar hit, rest 0.
- cw_tvalid / cr_tvalid / rc_tvalid  out  1 each  per-destination valid.
- cw_tready / cr_tready / rc_tready  in  1 each  per-destination ready.
- cr_credit_ret  in  1  pulse: one host read retired.
- drop_cnt  out  16  saturating count of discarded packets.
- credit_err  out  1  sticky: credit returned while the counter is already at NP_CREDITS.

Function
REQ-007 SHALL implement FSM states IDLE, PASS, DROP.
REQ-008 IDLE SHALL leave only when pkt_rdy=1 and fifo_empty=0.
REQ-009 SHALL route on the head sop beat using fmt=data[31:29] and type=data[28:24]:
- fmt 000/001 with type 00000 -> cr.
- fmt 010/011 with type 00000 -> cw.
- type 01010 (any fmt) -> rc.
- anything else -> DROP.
REQ-010 A head beat with sop=0 in IDLE SHALL enter DROP (resync).
REQ-011 A cr packet SHALL start only if the credit count is greater than 0. Otherwise the FSM SHALL stay in IDLE (head-of-line stall) with fifo_rdreq=0.
REQ-012 The credit count SHALL decrement when a cr packet starts and increment on cr_credit_ret. When both occur in the same cycle, the count SHALL be unchanged.
REQ-013 The credit count SHALL never exceed NP_CREDITS. An excess return SHALL be ignored and SHALL set credit_err.
REQ-014 In PASS: fifo_rdreq = !fifo_empty && (!out_valid || selected tready).
REQ-015 The output register SHALL load on fifo_rdreq, giving 1-cycle latency from pop to tvalid.
REQ-016 The output register SHALL hold while valid and not ready.
REQ-017 Only the selected destination's tvalid SHALL ever be 1.
REQ-018 m_tlast SHALL equal the popped eop bit, and m_tstrb SHALL equal the popped be.
REQ-019 In DROP: fifo_rdreq = !fifo_empty, and no tvalid SHALL be asserted.
REQ-020 pkt_pop SHALL be asserted when fifo_rdreq=1 and the head eop bit is 1, in any state.
REQ-021 On an eop pop the FSM SHALL return to IDLE, and the next packet SHALL NOT start until the last output beat is accepted.
REQ-022 drop_cnt SHALL increment once per dropped packet on its eop pop and SHALL saturate at 16'hFFFF.
REQ-023 A single-beat packet (sop=eop=1) SHALL be handled in one pop.

Reset
REQ-024 While axi_rst=0: FSM = IDLE, all tvalid = 0, fifo_rdreq = 0, pkt_pop = 0, m_tdata/m_tstrb/m_tuser/m_tlast = 0, credits = NP_CREDITS, drop_cnt = 0, credit_err = 0.
REQ-025 Reset mid-packet SHALL discard the output register. Leftover beats of that packet in the FIFO SHALL then be removed by the sop-resync DROP path (REQ-010).

Structure
REQ-026 Shared package rx_sched_pkg SHALL hold the fmt/type constants, the FIFO field offsets, and the state encoding.
REQ-027 The credit counter SHALL be a sub-module rx_np_credit, parameterised by NP_CREDITS, with outputs credit_avail and credit_err.

Verification
REQ-028 Single 3-beat MWr (data[31:24]=8'h40), ready tied 1 -> cw_tvalid for 3 consecutive cycles starting 1 cycle after the first pop, tlast on beat 3, one pkt_pop.
REQ-029 Five 1-beat MRd (8'h00), no cr_credit_ret -> 4 delivered on cr, the 5th stalls with fifo_rdreq=0; one cr_credit_ret -> the 5th is delivered.
REQ-030 CplD (8'h4A) with rc_tready toggling 1,0,1,0 -> no beat lost or duplicated, data held stable while not ready.
REQ-031 Message TLP (8'h30), 2 beats -> no tvalid asserted, drop_cnt = 1, next MWr routed normally.
REQ-032 axi_rst asserted after beat 1 of a 4-beat MWr -> outputs cleared; after release, the remaining 3 beats are dropped (drop_cnt = 1); a following CplD goes to rc.
REQ-033 cr_credit_ret with the counter at NP_CREDITS -> credit_err = 1, count stays 4; cr start and cr_credit_ret in the same cycle -> count unchanged.
